esc_mem_arb: RTL

- Single-port arbiter for ESC process/register RAM, shared by two requesters.
- ECAT side: datagram handler fifo-style byte interface (sof/eof/valid/read/addr/wdata -> rdata/ready). High priority, frame-tracked.
- PDI side: single-byte req/ack. Served in ECAT gaps, with a bounded-wait guarantee.
- Sits between dhsm_top's fifo interface and the RAM macro.

---
 rtl/esc_mem_pkg.sv | 24 ++
 rtl/esc_mem_tagpipe.sv | 33 +++
 rtl/esc_mem_arb.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/esc_mem_pkg.sv
// Shared encodings and defaults for the ESC memory arbiter and its tag pipeline.
package esc_mem_pkg;

  localparam int AW_DEF       = 16;
  localparam int DW_DEF       = 8;
  localparam int RAM_LAT_DEF  = 2;
  localparam int MAX_WAIT_DEF = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ECAT = 2'd1,
    OWN_PDI  = 2'd2
  } own_e;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FRAME = 1'b1;

  typedef struct packed {
    logic vld;
    own_e owner;
    logic rd;
  } tag_t;

endpackage

// File: rtl/esc_mem_tagpipe.sv
// Shift register that follows each RAM access until its data returns, so the
// completion stage knows who issued it and whether it was a read.
module esc_mem_tagpipe
  import esc_mem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vld_i,
  input  logic [1:0] owner_i,
  input  logic       rd_i,
  output logic       vld_o,
  output logic [1:0] owner_o,
  output logic       rd_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{vld: vld_i, owner: own_e'(owner_i), rd: rd_i};
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign vld_o   = pipe_q[DEPTH-1].vld;
  assign owner_o = pipe_q[DEPTH-1].owner;
  assign rd_o    = pipe_q[DEPTH-1].rd;

endmodule

// File: rtl/esc_mem_arb.sv
// Single-port RAM arbiter: the ECAT datagram port has priority, the PDI port is
// served in ECAT gaps and force-granted after MAX_WAIT lost cycles.
//
// state | meaning
// IDLE  | no ECAT frame open
// FRAME | sof granted, waiting for eof
module esc_mem_arb
  import esc_mem_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RAM_LAT  = RAM_LAT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ecat_sof,
  input  logic          ecat_eof,
  input  logic          ecat_valid,
  input  logic          ecat_read,
  input  logic [AW-1:0] ecat_addr,
  input  logic [DW-1:0] ecat_wdata,
  output logic [DW-1:0] ecat_rdata,
  output logic          ecat_ready,
  input  logic          pdi_req,
  input  logic          pdi_we,
  input  logic [AW-1:0] pdi_addr,
  input  logic [DW-1:0] pdi_wdata,
  output logic [DW-1:0] pdi_rdata,
  output logic          pdi_ack,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          frame_active,
  output logic          frame_err
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

  logic          ecat_busy_q, ecat_busy_d;
  logic          pdi_busy_q, pdi_busy_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          frame_q, frame_d;
  logic          frame_err_q, frame_err_d;

  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  logic          ecat_ready_q, ecat_ready_d;
  logic [DW-1:0] ecat_rdata_q, ecat_rdata_d;
  logic          pdi_ack_q, pdi_ack_d;
  logic [DW-1:0] pdi_rdata_q, pdi_rdata_d;

  logic          ecat_elig, pdi_elig;
  logic          grant_ecat, grant_pdi;
  logic [1:0]    tag_owner;
  logic          tag_rd;
  logic          tp_vld, tp_rd;
  logic [1:0]    tp_owner;
  logic          ecat_done, pdi_done;

  assign ecat_elig  = ecat_valid & ~ecat_busy_q;
  assign pdi_elig   = pdi_req & ~pdi_busy_q;
  assign grant_pdi  = pdi_elig & ((wait_q == WAIT_SAT) | ~ecat_elig);
  assign grant_ecat = ecat_elig & ~grant_pdi;

  // Busy drops on the edge that closes the completion cycle.
  assign ecat_busy_d = grant_ecat | (ecat_busy_q & ~ecat_ready_q);
  assign pdi_busy_d  = grant_pdi | (pdi_busy_q & ~pdi_ack_q);

  always_comb begin
    wait_d = wait_q;
    if (!pdi_req || grant_pdi) begin
      wait_d = '0;
    end else if (pdi_elig && (wait_q != WAIT_SAT)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_comb begin
    frame_d     = frame_q;
    frame_err_d = 1'b0;
    if (grant_ecat) begin
      frame_err_d = ecat_sof & (frame_q == ST_FRAME);
      if (ecat_eof) begin
        frame_d = ST_IDLE;
      end else if (ecat_sof) begin
        frame_d = ST_FRAME;
      end
    end
  end

  always_comb begin
    ram_en_d    = grant_ecat | grant_pdi;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    tag_owner   = OWN_NONE;
    tag_rd      = 1'b0;
    if (grant_pdi) begin
      ram_we_d    = pdi_we;
      ram_addr_d  = pdi_addr;
      ram_wdata_d = pdi_wdata;
      tag_owner   = OWN_PDI;
      tag_rd      = ~pdi_we;
    end else if (grant_ecat) begin
      ram_we_d    = ~ecat_read;
      ram_addr_d  = ecat_addr;
      ram_wdata_d = ecat_wdata;
      tag_owner   = OWN_ECAT;
      tag_rd      = ecat_read;
    end
  end

  esc_mem_tagpipe #(
    .DEPTH (RAM_LAT + 1)
  ) u_tagpipe (
    .clk     (clk),
    .rst     (rst),
    .vld_i   (ram_en_d),
    .owner_i (tag_owner),
    .rd_i    (tag_rd),
    .vld_o   (tp_vld),
    .owner_o (tp_owner),
    .rd_o    (tp_rd)
  );

  // The last tag stage lines up with the cycle RAM data is valid.
  assign ecat_done = tp_vld & (tp_owner == OWN_ECAT);
  assign pdi_done  = tp_vld & (tp_owner == OWN_PDI);

  always_comb begin
    ecat_ready_d = ecat_done;
    pdi_ack_d    = pdi_done;
    ecat_rdata_d = (ecat_done && tp_rd) ? ram_rdata : ecat_rdata_q;
    pdi_rdata_d  = (pdi_done && tp_rd) ? ram_rdata : pdi_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ecat_busy_q  <= 1'b0;
      pdi_busy_q   <= 1'b0;
      wait_q       <= '0;
      frame_q      <= ST_IDLE;
      frame_err_q  <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ecat_ready_q <= 1'b0;
      ecat_rdata_q <= '0;
      pdi_ack_q    <= 1'b0;
      pdi_rdata_q  <= '0;
    end else begin
      ecat_busy_q  <= ecat_busy_d;
      pdi_busy_q   <= pdi_busy_d;
      wait_q       <= wait_d;
      frame_q      <= frame_d;
      frame_err_q  <= frame_err_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ecat_ready_q <= ecat_ready_d;
      ecat_rdata_q <= ecat_rdata_d;
      pdi_ack_q    <= pdi_ack_d;
      pdi_rdata_q  <= pdi_rdata_d;
    end
  end

  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ecat_ready   = ecat_ready_q;
  assign ecat_rdata   = ecat_rdata_q;
  assign pdi_ack      = pdi_ack_q;
  assign pdi_rdata    = pdi_rdata_q;
  assign frame_active = (frame_q == ST_FRAME);
  assign frame_err    = frame_err_q;

endmodule
